// File: rtl/recip_core_multi.sv
// Multi-channel N-period reciprocal counter in the clk_fast domain, with a round-robin result port.
// Optional measurement timeout is compiled in with `define RECIP_TIMEOUT_EN.
module recip_core_multi #(
    parameter int NUM_CH         = 2,
    parameter int COARSE_WIDTH   = 24,
    parameter int CH_W           = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                    clk_fast,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       sensor,
    input  logic                    enable,
    input  logic [15:0]             n_cycles,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic                    res_valid,
    input  logic                    res_ack,
    output logic [CH_W-1:0]         res_ch,
    output logic [COARSE_WIDTH-1:0] res_coarse,
    output logic                    res_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("recip_core_multi: NUM_CH must be 1..16");
    end
    if (CH_W < $clog2(NUM_CH) || CH_W < 1) begin : g_bad_ch_w
        $error("recip_core_multi: CH_W too narrow for NUM_CH");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("recip_core_multi: TIMEOUT_CYCLES must be >= 2");
    end

`ifdef RECIP_TIMEOUT_EN
    localparam logic [COARSE_WIDTH-1:0] TO_VAL  = COARSE_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COARSE_WIDTH-1:0] TO_LAST = COARSE_WIDTH'(TIMEOUT_CYCLES - 1);
`endif

    function automatic logic [COARSE_WIDTH-1:0] sat_inc(input logic [COARSE_WIDTH-1:0] v);
        if (v == {COARSE_WIDTH{1'b1}}) begin
            return v;
        end else begin
            return v + COARSE_WIDTH'(1);
        end
    endfunction

    logic [NUM_CH-1:0]       s1_q, s2_q, s3_q, edge_s;
    ch_state_e               state_q  [NUM_CH];
    ch_state_e               state_d  [NUM_CH];
    logic [COARSE_WIDTH-1:0] cnt_q    [NUM_CH];
    logic [COARSE_WIDTH-1:0] cnt_d    [NUM_CH];
    logic [COARSE_WIDTH-1:0] result_q [NUM_CH];
    logic [COARSE_WIDTH-1:0] result_d [NUM_CH];
    logic [15:0]             edges_q  [NUM_CH];
    logic [15:0]             edges_d  [NUM_CH];
    logic [15:0]             neff_q   [NUM_CH];
    logic [15:0]             neff_d   [NUM_CH];
    logic [NUM_CH-1:0]       tflag_q, tflag_d, busy_d;
    logic [15:0]             n_eff_s;

    logic                    grant_vld_s, grant_s, port_free_s;
    logic [CH_W-1:0]         grant_ch_s, rr_ptr_q;
    logic [COARSE_WIDTH-1:0] grant_coarse_s;
    logic                    grant_tflag_s;

    logic                    res_valid_q, res_timeout_q;
    logic [CH_W-1:0]         res_ch_q;
    logic [COARSE_WIDTH-1:0] res_coarse_q;
    logic [NUM_CH-1:0]       ch_busy_q;

    assign edge_s      = s2_q & ~s3_q;
    assign n_eff_s     = (n_cycles < 16'd2) ? 16'd2 : n_cycles;
    assign port_free_s = ~res_valid_q | res_ack;
    assign grant_s     = grant_vld_s & port_free_s;

    // Round-robin pick of the first DONE channel at or after the pointer.
    always_comb begin : p_grant
        logic [CH_W:0] idx;
        logic          hit;
        grant_vld_s    = 1'b0;
        grant_ch_s     = '0;
        grant_coarse_s = '0;
        grant_tflag_s  = 1'b0;
        idx            = '0;
        hit            = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
            idx = (idx >= (CH_W+1)'(NUM_CH)) ? idx - (CH_W+1)'(NUM_CH) : idx;
            for (int j = 0; j < NUM_CH; j++) begin
                hit            = ~grant_vld_s & (state_q[j] == ST_DONE) & (idx == (CH_W+1)'(j));
                grant_ch_s     = hit ? CH_W'(j) : grant_ch_s;
                grant_coarse_s = hit ? result_q[j] : grant_coarse_s;
                grant_tflag_s  = hit ? tflag_q[j] : grant_tflag_s;
                grant_vld_s    = grant_vld_s | hit;
            end
        end
    end

    // Per-channel measurement FSM next-state logic.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            result_d[i] = result_q[i];
            edges_d[i]  = edges_q[i];
            neff_d[i]   = neff_q[i];
            tflag_d[i]  = tflag_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (edge_s[i] && enable) begin
                        state_d[i] = ST_MEAS;
                        cnt_d[i]   = '0;
                        edges_d[i] = 16'd1;
                        neff_d[i]  = n_eff_s;
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_MEAS: begin
                    // enable low takes priority over a coincident stop edge.
                    if (!enable) begin
                        state_d[i] = ST_IDLE;
                    end else if (edge_s[i] && ((edges_q[i] + 16'd1) == neff_q[i])) begin
                        state_d[i]  = ST_DONE;
                        result_d[i] = sat_inc(cnt_q[i]);
                        tflag_d[i]  = 1'b0;
`ifdef RECIP_TIMEOUT_EN
                    end else if (cnt_q[i] == TO_LAST) begin
                        state_d[i]  = ST_DONE;
                        result_d[i] = TO_VAL;
                        tflag_d[i]  = 1'b1;
`endif
                    end else begin
                        cnt_d[i]   = sat_inc(cnt_q[i]);
                        edges_d[i] = edges_q[i] + {15'd0, edge_s[i]};
                    end
                end
                ST_DONE: begin
                    if (grant_s && (grant_ch_s == CH_W'(i))) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        state_d[i] = ST_DONE;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
            busy_d[i] = (state_d[i] != ST_IDLE);
        end
    end

    // Sensor synchronisers and per-channel state registers.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            tflag_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= ST_IDLE;
                cnt_q[i]    <= '0;
                result_q[i] <= '0;
                edges_q[i]  <= 16'd0;
                neff_q[i]   <= 16'd0;
            end
        end else begin
            s1_q    <= sensor;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            tflag_q <= tflag_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                result_q[i] <= result_d[i];
                edges_q[i]  <= edges_d[i];
                neff_q[i]   <= neff_d[i];
            end
        end
    end

    // Result port register, round-robin pointer and busy flags.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            res_valid_q   <= 1'b0;
            res_ch_q      <= '0;
            res_coarse_q  <= '0;
            res_timeout_q <= 1'b0;
            rr_ptr_q      <= '0;
            ch_busy_q     <= '0;
        end else begin
            ch_busy_q <= busy_d;
            if (grant_s) begin
                res_valid_q   <= 1'b1;
                res_ch_q      <= grant_ch_s;
                res_coarse_q  <= grant_coarse_s;
                res_timeout_q <= grant_tflag_s;
                rr_ptr_q      <= (grant_ch_s == CH_W'(NUM_CH - 1)) ? '0 : grant_ch_s + CH_W'(1);
            end else if (res_ack) begin
                res_valid_q <= 1'b0;
            end else begin
                res_valid_q <= res_valid_q;
            end
        end
    end

    assign res_valid   = res_valid_q;
    assign res_ch      = res_ch_q;
    assign res_coarse  = res_coarse_q;
    assign res_timeout = res_timeout_q;
    assign ch_busy     = ch_busy_q;

endmodule
